layered_sprite_compositor: RTL and testbench

//  Pipelined N-layer sprite compositor for the VGA pixel path; generalises the fixed bird/pipe/title renderer.
//  Per pixel: computes each layer's bounding-box hit and scaled ROM row/col, then aligns hits to the external ROM latency.

---
 rtl/layered_sprite_compositor.sv | 163 ++++++++++++++++
 tb/tb_layered_sprite_compositor.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layered_sprite_compositor.sv
// N-layer sprite compositor: per-layer bounding-box hit and ROM addressing, ROM-latency
// alignment, priority/transparency select, and frame-stepped fade dimming of the result.
module layered_sprite_compositor #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned COORD_W    = 32,
    parameter int unsigned SIZE_W     = 12,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned ROM_LAT    = 1,
    parameter logic [23:0] KEY_COLOUR = 24'hFF0096,
    parameter logic [23:0] BG_COLOUR  = 24'h000000,
    parameter int unsigned DIM_MAX    = 3
) (
    input  logic                           VGA_clk,
    input  logic                           rst,
    input  logic signed [COORD_W-1:0]      X,
    input  logic signed [COORD_W-1:0]      Y,
    input  logic                           display_on,
    input  logic                           frame_start,
    input  logic [NUM_LAYERS-1:0]          layer_en,
    input  logic [NUM_LAYERS*COORD_W-1:0]  layer_x,
    input  logic [NUM_LAYERS*COORD_W-1:0]  layer_y,
    input  logic [NUM_LAYERS*SIZE_W-1:0]   layer_w,
    input  logic [NUM_LAYERS*SIZE_W-1:0]   layer_h,
    output logic [NUM_LAYERS*ADDR_W-1:0]   rom_row,
    output logic [NUM_LAYERS*ADDR_W-1:0]   rom_col,
    input  logic [NUM_LAYERS*24-1:0]       rom_colour,
    input  logic                           dim_req,
    output logic [1:0]                     dim_level,
    output logic [23:0]                    RGB
);

    localparam logic [1:0] LVL_MAX = 2'(DIM_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FADE_IN,
        S_DIMMED,
        S_FADE_OUT
    } fade_t;

    fade_t                         state_q;
    logic [1:0]                    level_q;
    logic [NUM_LAYERS-1:0]         hit_d, hit_q;
    logic                          don_q;
    logic [NUM_LAYERS*ADDR_W-1:0]  row_d, row_q, col_d, col_q;
    logic [NUM_LAYERS-1:0]         hit_dl_q [ROM_LAT];
    logic [ROM_LAT-1:0]            don_dl_q;
    logic [23:0]                   colour_d, rgb_d, rgb_q;

    always_comb begin : stage0
        logic signed [COORD_W-1:0] dx, dy, w_ext, h_ext;
        dx    = '0;
        dy    = '0;
        w_ext = '0;
        h_ext = '0;
        hit_d = '0;
        row_d = '0;
        col_d = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            dx    = X - $signed(layer_x[i*COORD_W +: COORD_W]);
            dy    = Y - $signed(layer_y[i*COORD_W +: COORD_W]);
            w_ext = $signed({{(COORD_W - SIZE_W){1'b0}}, layer_w[i*SIZE_W +: SIZE_W]});
            h_ext = $signed({{(COORD_W - SIZE_W){1'b0}}, layer_h[i*SIZE_W +: SIZE_W]});
            hit_d[i] = layer_en[i] && !dx[COORD_W-1] && (dx < w_ext)
                                   && !dy[COORD_W-1] && (dy < h_ext);
            if (hit_d[i]) begin
                row_d[i*ADDR_W +: ADDR_W] = ADDR_W'(dy >>> SCALE_LOG2);
                col_d[i*ADDR_W +: ADDR_W] = ADDR_W'(dx >>> SCALE_LOG2);
            end
        end
    end

    // Lowest-index opaque texel wins; a key-coloured texel falls through to the next layer.
    always_comb begin : compose
        logic found;
        found    = 1'b0;
        colour_d = BG_COLOUR;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!found && hit_dl_q[ROM_LAT-1][i] && (rom_colour[i*24 +: 24] != KEY_COLOUR)) begin
                colour_d = rom_colour[i*24 +: 24];
                found    = 1'b1;
            end
        end
        if (!don_dl_q[ROM_LAT-1]) begin
            colour_d = BG_COLOUR;
        end
        rgb_d = {colour_d[23:16] >> level_q, colour_d[15:8] >> level_q, colour_d[7:0] >> level_q};
    end

    always_ff @(posedge VGA_clk) begin
        if (rst) begin
            row_q    <= '0;
            col_q    <= '0;
            hit_q    <= '0;
            don_q    <= 1'b0;
            don_dl_q <= '0;
            rgb_q    <= BG_COLOUR;
            for (int unsigned k = 0; k < ROM_LAT; k++) begin
                hit_dl_q[k] <= '0;
            end
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            hit_q       <= hit_d;
            don_q       <= display_on;
            hit_dl_q[0] <= hit_q;
            don_dl_q[0] <= don_q;
            for (int unsigned k = 1; k < ROM_LAT; k++) begin
                hit_dl_q[k] <= hit_dl_q[k-1];
                don_dl_q[k] <= don_dl_q[k-1];
            end
            rgb_q <= rgb_d;
        end
    end

    always_ff @(posedge VGA_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            level_q <= '0;
        end else if (frame_start) begin
            case (state_q)
                S_IDLE: begin
                    if (dim_req) begin
                        level_q <= 2'd1;
                        state_q <= (LVL_MAX == 2'd1) ? S_DIMMED : S_FADE_IN;
                    end
                end
                S_FADE_IN, S_FADE_OUT: begin
                    if (dim_req) begin
                        if (level_q < LVL_MAX) begin
                            level_q <= level_q + 2'd1;
                            state_q <= (level_q + 2'd1 == LVL_MAX) ? S_DIMMED : S_FADE_IN;
                        end else begin
                            state_q <= S_DIMMED;
                        end
                    end else if (level_q > 2'd0) begin
                        level_q <= level_q - 2'd1;
                        state_q <= (level_q == 2'd1) ? S_IDLE : S_FADE_OUT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_DIMMED: begin
                    if (!dim_req) begin
                        level_q <= level_q - 2'd1;
                        state_q <= (level_q == 2'd1) ? S_IDLE : S_FADE_OUT;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    level_q <= '0;
                end
            endcase
        end
    end

    assign rom_row   = row_q;
    assign rom_col   = col_q;
    assign dim_level = level_q;
    assign RGB       = rgb_q;

endmodule

// File: tb/tb_layered_sprite_compositor.sv
// Scoreboard bench for layered_sprite_compositor: directed vectors plus a region sweep
// against a reference model; expectations are tagged with the cycle they must appear in.
module tb_layered_sprite_compositor;

    localparam int NL  = 4;
    localparam int CW  = 32;
    localparam int SW  = 12;
    localparam int AW  = 8;
    localparam int SL  = 1;
    localparam int RL  = 2;
    localparam int DMX = 3;
    localparam logic [23:0] KEY = 24'hFF0096;
    localparam logic [23:0] BG  = 24'h000000;

    logic                    VGA_clk = 1'b0;
    logic                    rst;
    logic signed [CW-1:0]    X, Y;
    logic                    display_on, frame_start, dim_req;
    logic [NL-1:0]           layer_en;
    logic [NL*CW-1:0]        layer_x, layer_y;
    logic [NL*SW-1:0]        layer_w, layer_h;
    logic [NL*AW-1:0]        rom_row, rom_col;
    logic [NL*24-1:0]        rom_colour;
    logic [1:0]              dim_level;
    logic [23:0]             RGB;

    layered_sprite_compositor #(
        .NUM_LAYERS(NL), .COORD_W(CW), .SIZE_W(SW), .ADDR_W(AW), .SCALE_LOG2(SL),
        .ROM_LAT(RL), .KEY_COLOUR(KEY), .BG_COLOUR(BG), .DIM_MAX(DMX)
    ) dut (
        .VGA_clk(VGA_clk), .rst(rst), .X(X), .Y(Y), .display_on(display_on),
        .frame_start(frame_start), .layer_en(layer_en), .layer_x(layer_x), .layer_y(layer_y),
        .layer_w(layer_w), .layer_h(layer_h), .rom_row(rom_row), .rom_col(rom_col),
        .rom_colour(rom_colour), .dim_req(dim_req), .dim_level(dim_level), .RGB(RGB)
    );

    always #5 VGA_clk = ~VGA_clk;

    int cyc = 0;
    always @(posedge VGA_clk) cyc <= cyc + 1;

    int          lx [NL];
    int          ly [NL];
    int          lw [NL];
    int          lh [NL];
    logic [23:0] rom_const [NL];
    bit          pattern;

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            layer_x[i*CW +: CW] = lx[i];
            layer_y[i*CW +: CW] = ly[i];
            layer_w[i*SW +: SW] = lw[i][SW-1:0];
            layer_h[i*SW +: SW] = lh[i][SW-1:0];
        end
    end

    function automatic logic [23:0] texel(int i, logic [7:0] r, logic [7:0] c);
        if (!pattern) return rom_const[i];
        if ((int'(r ^ c) + i) % 7 == 0) return KEY;
        return {i[1:0], 6'h15, r, c};
    endfunction

    // Sprite ROM with RL register stages
    logic [NL*24-1:0] rom_pipe [RL];
    always @(posedge VGA_clk) begin
        for (int i = 0; i < NL; i++)
            rom_pipe[0][i*24 +: 24] <= texel(i, rom_row[i*AW +: AW], rom_col[i*AW +: AW]);
        for (int j = 1; j < RL; j++)
            rom_pipe[j] <= rom_pipe[j-1];
    end
    assign rom_colour = rom_pipe[RL-1];

    function automatic logic [23:0] dimc(logic [23:0] c, int l);
        return {c[23:16] >> l, c[15:8] >> l, c[7:0] >> l};
    endfunction

    function automatic logic [23:0] model_rgb(int x, int y, bit don, int l);
        logic [23:0] t;
        if (!don) return dimc(BG, l);
        for (int i = 0; i < NL; i++) begin
            int dx, dy;
            dx = x - lx[i];
            dy = y - ly[i];
            if (layer_en[i] && dx >= 0 && dx < lw[i] && dy >= 0 && dy < lh[i]) begin
                t = texel(i, 8'(dy >>> SL), 8'(dx >>> SL));
                if (t != KEY) return dimc(t, l);
            end
        end
        return dimc(BG, l);
    endfunction

    function automatic void model_addr(int x, int y, output logic [NL*AW-1:0] rows,
                                       output logic [NL*AW-1:0] cols);
        rows = '0;
        cols = '0;
        for (int i = 0; i < NL; i++) begin
            int dx, dy;
            dx = x - lx[i];
            dy = y - ly[i];
            if (layer_en[i] && dx >= 0 && dx < lw[i] && dy >= 0 && dy < lh[i]) begin
                rows[i*AW +: AW] = 8'(dy >>> SL);
                cols[i*AW +: AW] = 8'(dx >>> SL);
            end
        end
    endfunction

    typedef struct {
        int          tag;
        int          nid;
        bit          crgb;
        logic [23:0] rgb;
        bit          cdim;
        logic [1:0]  dim;
    } oexp_t;

    typedef struct {
        int              tag;
        int              nid;
        logic [NL*AW-1:0] rows;
        logic [NL*AW-1:0] cols;
    } aexp_t;

    oexp_t oq[$];
    aexp_t aq[$];
    string names[$];
    int    tests = 0;
    int    fails = 0;
    bit    done  = 0;

    task automatic step();
        @(posedge VGA_clk);
        #1;
    endtask

    task automatic push_o(int tag, string nm, bit crgb, logic [23:0] rgb, bit cdim, logic [1:0] dim);
        oexp_t e;
        int j;
        names.push_back(nm);
        e.tag = tag; e.nid = names.size() - 1;
        e.crgb = crgb; e.rgb = rgb; e.cdim = cdim; e.dim = dim;
        j = oq.size();
        while (j > 0 && oq[j-1].tag > tag) j--;
        oq.insert(j, e);
    endtask

    task automatic push_a(int tag, string nm, logic [NL*AW-1:0] rows, logic [NL*AW-1:0] cols);
        aexp_t a;
        names.push_back(nm);
        a.tag = tag; a.nid = names.size() - 1; a.rows = rows; a.cols = cols;
        aq.push_back(a);
    endtask

    task automatic drive(int x, int y, bit don);
        step();
        X = x;
        Y = y;
        display_on = don;
    endtask

    task automatic pix(int x, int y, bit don, string nm, logic [23:0] exp, bit ca,
                       logic [NL*AW-1:0] rows, logic [NL*AW-1:0] cols);
        drive(x, y, don);
        push_o(cyc + RL + 2, nm, 1'b1, exp, 1'b0, 2'd0);
        if (ca) push_a(cyc + 1, {nm, "_addr"}, rows, cols);
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 1'b0);
    endtask

    task automatic pulse(bit req, string nm, logic [1:0] lvl);
        step();
        dim_req = req;
        frame_start = 1'b1;
        push_o(cyc + 1, nm, 1'b0, '0, 1'b1, lvl);
        step();
        frame_start = 1'b0;
        push_o(cyc + 1, {nm, "_hold"}, 1'b0, '0, 1'b1, lvl);
    endtask

    // Monitor: compares every expectation due in the current cycle
    initial begin
        forever begin
            @(negedge VGA_clk);
            while (oq.size() > 0 && oq[0].tag <= cyc) begin
                oexp_t e;
                e = oq.pop_front();
                if (e.tag != cyc) begin
                    tests++; fails++;
                    $display("FAIL %s: slot missed, due cycle %0d, now %0d", names[e.nid], e.tag, cyc);
                end else begin
                    if (e.crgb) begin
                        tests++;
                        if (RGB !== e.rgb) begin
                            fails++;
                            $display("FAIL %s: RGB got %06h expected %06h", names[e.nid], RGB, e.rgb);
                        end
                    end
                    if (e.cdim) begin
                        tests++;
                        if (dim_level !== e.dim) begin
                            fails++;
                            $display("FAIL %s: dim_level got %0d expected %0d", names[e.nid], dim_level, e.dim);
                        end
                    end
                end
            end
            while (aq.size() > 0 && aq[0].tag <= cyc) begin
                aexp_t a;
                a = aq.pop_front();
                tests++;
                if (a.tag != cyc || rom_row !== a.rows || rom_col !== a.cols) begin
                    fails++;
                    $display("FAIL %s: row/col got %08h/%08h expected %08h/%08h (due %0d now %0d)",
                             names[a.nid], rom_row, rom_col, a.rows, a.cols, a.tag, cyc);
                end
            end
            if (done) begin
                tests++;
                if (oq.size() + aq.size() != 0) begin
                    fails++;
                    $display("FAIL drain: got %0d pending expectations, expected 0", oq.size() + aq.size());
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    initial begin
        rst = 1'b1; X = 0; Y = 0; display_on = 1'b0; frame_start = 1'b0; dim_req = 1'b0;
        layer_en = '0; pattern = 1'b0;
        for (int i = 0; i < NL; i++) begin
            lx[i] = 500; ly[i] = 500; lw[i] = 0; lh[i] = 0; rom_const[i] = 24'h000000;
        end

        step();
        push_o(cyc + 1, "reset", 1'b1, BG, 1'b1, 2'd0);
        push_a(cyc + 1, "reset_addr", '0, '0);
        step();
        rst = 1'b0;
        idle(4);

        // Single layer, origin / far corner / just outside
        lx[0] = 100; ly[0] = 100; lw[0] = 32; lh[0] = 32; rom_const[0] = 24'h112233;
        layer_en = 4'b0001;
        pix(100, 100, 1'b1, "t1_origin",     24'h112233, 1'b1, 32'h0, 32'h0);
        pix(131, 131, 1'b1, "t1_far_corner", 24'h112233, 1'b1, 32'h0000000F, 32'h0000000F);
        pix(132, 100, 1'b1, "t1_right_miss", BG,         1'b1, 32'h0, 32'h0);
        pix(100, 99,  1'b1, "t1_top_miss",   BG,         1'b1, 32'h0, 32'h0);
        idle(6);

        // Overlap and transparency
        lx[1] = 104; ly[1] = 100; lw[1] = 32; lh[1] = 32;
        rom_const[0] = KEY; rom_const[1] = 24'h00FF00;
        layer_en = 4'b0011;
        idle(2);
        pix(110, 110, 1'b1, "t2_key_fallthrough", 24'h00FF00, 1'b1, 32'h00000505, 32'h00000305);
        pix(102, 105, 1'b1, "t2_key_no_lower",    BG,         1'b1, 32'h00000002, 32'h00000001);
        idle(6);
        rom_const[0] = 24'hFF0000;
        idle(2);
        pix(110, 110, 1'b1, "t2_opaque_top",   24'hFF0000, 1'b0, '0, '0);
        pix(135, 110, 1'b1, "t2_layer1_only",  24'h00FF00, 1'b0, '0, '0);
        idle(6);

        // Edges with a negative origin, zero-size layers
        lx[0] = -4; ly[0] = 10; lw[0] = 8; lh[0] = 8; rom_const[0] = 24'h445566;
        layer_en = 4'b0001;
        idle(2);
        pix(-5, 12, 1'b1, "t3_left_miss",     BG,         1'b1, 32'h0, 32'h0);
        pix(-4, 12, 1'b1, "t3_left_edge",     24'h445566, 1'b1, 32'h1, 32'h0);
        pix( 3, 12, 1'b1, "t3_right_edge",    24'h445566, 1'b1, 32'h1, 32'h3);
        pix( 4, 12, 1'b1, "t3_right_miss",    BG,         1'b1, 32'h0, 32'h0);
        pix( 0, 17, 1'b1, "t3_bottom_edge",   24'h445566, 1'b1, 32'h3, 32'h2);
        pix( 0, 18, 1'b1, "t3_bottom_miss",   BG,         1'b1, 32'h0, 32'h0);
        idle(6);
        lw[0] = 0;
        idle(2);
        pix(-4, 12, 1'b1, "t3_zero_width",    BG,         1'b1, 32'h0, 32'h0);
        idle(6);
        lw[0] = 8; lh[0] = 0;
        idle(2);
        pix(-4, 10, 1'b1, "t3_zero_height",   BG,         1'b1, 32'h0, 32'h0);
        idle(6);

        // Fade sequence
        lx[0] = 0; ly[0] = 0; lw[0] = 16; lh[0] = 16; rom_const[0] = 24'h80FF40;
        idle(2);
        pulse(1'b1, "t4_fade1", 2'd1);
        pulse(1'b1, "t4_fade2", 2'd2);
        pulse(1'b1, "t4_fade3", 2'd3);
        pulse(1'b1, "t4_fade4_sat", 2'd3);
        pix(5, 5, 1'b1, "t4_dim3_colour", 24'h101F08, 1'b0, '0, '0);
        idle(6);
        step();
        dim_req = 1'b0;
        push_o(cyc + 1, "t4_no_frame", 1'b0, '0, 1'b1, 2'd3);
        idle(2);
        pulse(1'b0, "t4_out2", 2'd2);
        pix(5, 5, 1'b1, "t4_dim2_colour", 24'h203F10, 1'b0, '0, '0);
        idle(6);
        pulse(1'b0, "t4_out1", 2'd1);
        pulse(1'b1, "t4_reverse_up", 2'd2);
        pulse(1'b0, "t4_out_again", 2'd1);
        pulse(1'b0, "t4_out0", 2'd0);
        pulse(1'b0, "t4_idle_stays", 2'd0);

        // display_on low while hitting; reset with pixels in flight
        pix(5, 5, 1'b0, "t5_display_off", BG, 1'b1, 32'h2, 32'h2);
        idle(6);
        pulse(1'b1, "t5_dim1", 2'd1);
        pulse(1'b1, "t5_dim2", 2'd2);
        pulse(1'b1, "t5_dim3", 2'd3);
        drive(5, 5, 1'b1);
        drive(6, 6, 1'b1);
        step();
        rst = 1'b1;
        display_on = 1'b0;
        push_o(cyc + 1, "t5_rst", 1'b1, BG, 1'b1, 2'd0);
        push_a(cyc + 1, "t5_rst_addr", '0, '0);
        step();
        rst = 1'b0;
        push_o(cyc + 1, "t5_drop1", 1'b1, BG, 1'b1, 2'd0);
        push_o(cyc + 2, "t5_drop2", 1'b1, BG, 1'b1, 2'd0);
        push_o(cyc + 3, "t5_drop3", 1'b1, BG, 1'b1, 2'd0);
        idle(4);
        pulse(1'b1, "t5_idle_after_rst", 2'd1);
        pulse(1'b0, "t5_back_to_0", 2'd0);
        idle(4);

        // Region sweep, all layers, patterned ROM
        pattern = 1'b1;
        lx[0] = -6;  ly[0] = -4; lw[0] = 40;  lh[0] = 30;
        lx[1] = 20;  ly[1] = 10; lw[1] = 64;  lh[1] = 48;
        lx[2] = 100; ly[2] = 50; lw[2] = 0;   lh[2] = 20;
        lx[3] = 2;   ly[3] = 1;  lw[3] = 180; lh[3] = 90;
        layer_en = 4'b1111;
        idle(4);
        for (int y = 0; y < 100; y++) begin
            for (int x = -4; x < 196; x++) begin
                logic [NL*AW-1:0] er, ec;
                bit don;
                don = (x >= 0) && (x < 190);
                model_addr(x, y, er, ec);
                pix(x, y, don, $sformatf("sweep_%0d_%0d", x, y), model_rgb(x, y, don, 0), 1'b1, er, ec);
            end
        end
        idle(8);
        done = 1'b1;
        repeat (5) step();
        $display("FAIL watchdog: monitor ended nothing, expected summary and finish");
        $fatal(1);
    end

endmodule
